bf_ram_dp_clr: RTL and testbench
================================

// Module: bf_ram_dp_clr
// PURPOSE
//   Parametrised simple-dual-port data RAM for the brainfuck core: one write port, one read port.
//   Registered read data carries a valid flag, and same-address write/read bypass is selectable.
//   A built-in clear sequencer zeroes the array one word per cycle, after reset or on request.
//   This replaces the single-cycle bulk clear, which does not map to block RAM.
//   Sits between the core's data-pointer datapath and its tape storage.
// PARAMETERS
//   DATA_W     8    data word width in bits
//   DEPTH      512  number of words; need not be a power of two
//   ADDR_W     9    address width; must satisfy 2**ADDR_W >= DEPTH
//   WR_BYPASS  1    1: same-cycle same-address read returns new data; 0: returns old data
// PORTS
//   clk       in   1       clock; all logic on rising edge
//   reset     in   1       synchronous, active-low reset
//   clear_rq  in   1       pulse: zero the whole array
//   busy      out  1       clear sequence in progress; port accesses ignored
//   wr_en     in   1       write strobe
//   wr_addr   in   ADDR_W  write address
//   wr_data   in   DATA_W  write data
//   rd_en     in   1       read strobe
//   rd_addr   in   ADDR_W  read address
//   rd_data   out  DATA_W  registered read data
//   rd_valid  out  1       rd_data updated by a read accepted on the previous edge
// BEHAVIOUR
//   - Reset: an edge with reset=0 sets state=CLEAR, clr_ptr=0, busy=1, rd_data=0, rd_valid=0.
//   - Array contents are not cleared on the reset edge itself; the sequencer does the clearing.
//   - FSM states: IDLE, CLEAR.
//     - CLEAR, each edge with reset=1: mem[clr_ptr]<=0.
//     - If clr_ptr==DEPTH-1: state<=IDLE, busy<=0; otherwise clr_ptr<=clr_ptr+1.
//     - Result: busy stays 1 for exactly DEPTH edges after reset is released.
//     - IDLE with clear_rq=1: state<=CLEAR, clr_ptr<=0, busy<=1 on that edge.
//     - clear_rq while in CLEAR is ignored; the sequence neither restarts nor extends.
//   - Reset asserted mid-clear restarts the sequence at address 0.
//   - While busy=1:
//     - wr_en and rd_en are ignored; no memory update.
//     - rd_valid<=0; rd_data holds its value.
//   - Write (IDLE, wr_en=1, wr_addr<DEPTH): mem[wr_addr]<=wr_data on the edge.
//   - wr_addr>=DEPTH: write dropped silently.
//   - Read (IDLE, rd_en=1): latency 1.
//     - On the edge: rd_data<=mem[rd_addr] and rd_valid<=1.
//     - rd_addr>=DEPTH: rd_data<=0 and rd_valid<=1.
//   - rd_en=0: rd_valid<=0; rd_data holds its last value (no return to 0).
//   - Simultaneous wr_en and rd_en with wr_addr==rd_addr (<DEPTH):
//     - WR_BYPASS=1: rd_data<=wr_data.
//     - WR_BYPASS=0: rd_data<=previous mem contents.
//     - In both cases memory is updated.
//   - Back-to-back reads and writes are accepted every cycle; there is no backpressure other than busy.
//   - clear_rq together with wr_en/rd_en in IDLE:
//     - The clear takes priority; the access is dropped and rd_valid<=0.
// TESTING
//   1. Reset 2 cycles, release; count busy -> high for exactly 512 cycles.
//      Then read addr 5 -> rd_data=8'h00, rd_valid=1 one cycle later.
//   2. Write 8'hA5 to addr 3, then read addr 3 on the next cycle.
//      -> rd_data=8'hA5, rd_valid=1; with rd_en low the following cycle, rd_valid=0 and rd_data stays 8'hA5.
//   3. Same cycle: write 8'h3C to addr 7 and read addr 7 (old value 8'h11).
//      -> WR_BYPASS=1 gives rd_data=8'h3C; WR_BYPASS=0 gives 8'h11.
//      A re-read then gives 8'h3C in both builds.
//   4. Fill addr 0..9 with nonzero data, pulse clear_rq, pulse clear_rq again 100 cycles later.
//      -> busy high for exactly 512 cycles from the first pulse; afterwards addr 0..9 read 8'h00.
//   5. DEPTH=300, ADDR_W=9: write 8'hFF to addr 310, then read addr 310.
//      -> rd_data=8'h00, rd_valid=1; addr 299 is unaffected.
//   6. Assert reset at clr_ptr=200 during a clear, hold 1 cycle, release.
//      -> busy remains high for 512 cycles after release; a write issued during busy is ignored.

Source files
------------

// File: rtl/bf_ram_dp_clr.sv
// bf_ram_dp_clr: simple-dual-port data RAM for the brainfuck core (one write port, one read port).
// Read data is registered and carries a valid flag. A same-address write/read in the same cycle
// returns either the new data (WR_BYPASS=1) or the old contents (WR_BYPASS=0). A clear sequencer
// zeroes the array one word per cycle after reset or on clear_rq_i, so the array maps onto block RAM.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-low reset; restarts the clear sequence at address 0
//   clear_rq_i   pulse: zero the whole array (ignored while a clear is already running)
//   busy_o       clear in progress; port accesses are ignored
//   wr_en_i      write strobe
//   wr_addr_i    write address; addresses >= DEPTH are dropped
//   wr_data_i    write data
//   rd_en_i      read strobe
//   rd_addr_i    read address; addresses >= DEPTH read as zero
//   rd_data_o    registered read data; holds its value when no read is accepted
//   rd_valid_o   rd_data_o was updated by a read accepted on the previous edge
module bf_ram_dp_clr #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 512,
   parameter int unsigned ADDR_W    = 9,
   parameter bit          WR_BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_rq_i,
   output logic              busy_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
   // One extra bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                wr_in_range;
   logic                rd_in_range;

   assign wr_in_range = ({1'b0, wr_addr_i} < DepthExt);
   assign rd_in_range = ({1'b0, rd_addr_i} < DepthExt);

   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = clr_ptr_q;
      mem_wdata  = '0;

      unique case (state_q)
         StClear: begin
            // clear_rq_i is deliberately not looked at here: no restart, no extension.
            mem_we = 1'b1;
            if (clr_ptr_q == LastAddr) begin
               state_d = StIdle;
            end else begin
               clr_ptr_d = clr_ptr_q + 1'b1;
            end
         end
         StIdle: begin
            if (clear_rq_i) begin
               // Clear wins over any access presented on the same edge.
               state_d   = StClear;
               clr_ptr_d = '0;
            end else begin
               if (wr_en_i && wr_in_range) begin
                  mem_we    = 1'b1;
                  mem_waddr = wr_addr_i;
                  mem_wdata = wr_data_i;
               end
               if (rd_en_i) begin
                  rd_valid_d = 1'b1;
                  if (!rd_in_range) begin
                     rd_data_d = '0;
                  end else if (WR_BYPASS && wr_en_i && (wr_addr_i == rd_addr_i)) begin
                     rd_data_d = wr_data_i;
                  end else begin
                     rd_data_d = mem_q[rd_addr_i];
                  end
               end
            end
         end
      endcase

      // The reset edge itself leaves the array untouched.
      if (!reset) begin
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StClear;
         clr_ptr_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Array storage kept free of reset so it infers block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign busy_o     = (state_q == StClear);
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_bf_ram_dp_clr.sv
// Bench for bf_ram_dp_clr. Three builds share one stimulus stream:
//   a: DEPTH=512, WR_BYPASS=1   b: DEPTH=512, WR_BYPASS=0   c: DEPTH=300, WR_BYPASS=1
// Stimulus pushes expectations (with the cycle they fall due) into a scoreboard queue; a monitor
// on the falling edge pops and compares them against what the DUTs present.
module tb_bf_ram_dp_clr;

   logic       clk;
   logic       reset;
   logic       clear_rq;
   logic       wr_en;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [8:0] rd_addr;

   logic       busy_a, busy_b, busy_c;
   logic [7:0] rd_data_a, rd_data_b, rd_data_c;
   logic       rd_valid_a, rd_valid_b, rd_valid_c;

   int cyc = 0;
   int n_run = 0;
   int n_fail = 0;

   typedef enum int {KRead, KHold, KVal} kind_e;
   typedef struct {
      kind_e kind;
      int    due;
      int    ea, eb, ec;
      int    ga, gb, gc;
      string name;
   } sb_t;
   sb_t sb[$];

   bf_ram_dp_clr #(.DATA_W(8), .DEPTH(512), .ADDR_W(9), .WR_BYPASS(1'b1)) u_dut_a (
      .clk(clk), .reset(reset), .clear_rq_i(clear_rq), .busy_o(busy_a),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a)
   );

   bf_ram_dp_clr #(.DATA_W(8), .DEPTH(512), .ADDR_W(9), .WR_BYPASS(1'b0)) u_dut_b (
      .clk(clk), .reset(reset), .clear_rq_i(clear_rq), .busy_o(busy_b),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b)
   );

   bf_ram_dp_clr #(.DATA_W(8), .DEPTH(300), .ADDR_W(9), .WR_BYPASS(1'b1)) u_dut_c (
      .clk(clk), .reset(reset), .clear_rq_i(clear_rq), .busy_o(busy_c),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_c), .rd_valid_o(rd_valid_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / scoreboard checker.
   always @(negedge clk) begin
      sb_t e;
      bit  got_rd;
      got_rd = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         n_run++;
         if (e.due != cyc) begin
            n_fail++;
            $display("FAIL %s: check due at cycle %0d, reached at cycle %0d", e.name, e.due, cyc);
         end else if (e.kind == KRead) begin
            got_rd = 1'b1;
            if (!(rd_valid_a && rd_valid_b && rd_valid_c) || int'(rd_data_a) != e.ea ||
                int'(rd_data_b) != e.eb || int'(rd_data_c) != e.ec) begin
               n_fail++;
               $display("FAIL %s: got data a=%0h b=%0h c=%0h valid=%b%b%b, exp a=%0h b=%0h c=%0h valid=111",
                        e.name, rd_data_a, rd_data_b, rd_data_c, rd_valid_a, rd_valid_b,
                        rd_valid_c, e.ea, e.eb, e.ec);
            end
         end else if (e.kind == KHold) begin
            if (rd_valid_a || rd_valid_b || rd_valid_c || int'(rd_data_a) != e.ea ||
                int'(rd_data_b) != e.eb || int'(rd_data_c) != e.ec) begin
               n_fail++;
               $display("FAIL %s: got data a=%0h b=%0h c=%0h valid=%b%b%b, exp a=%0h b=%0h c=%0h valid=000",
                        e.name, rd_data_a, rd_data_b, rd_data_c, rd_valid_a, rd_valid_b,
                        rd_valid_c, e.ea, e.eb, e.ec);
            end
         end else begin
            if (e.ga != e.ea || e.gb != e.eb || e.gc != e.ec) begin
               n_fail++;
               $display("FAIL %s: got a=%0d b=%0d c=%0d, exp a=%0d b=%0d c=%0d",
                        e.name, e.ga, e.gb, e.gc, e.ea, e.eb, e.ec);
            end
         end
      end
      if (!got_rd && (rd_valid_a || rd_valid_b || rd_valid_c)) begin
         n_run++;
         n_fail++;
         $display("FAIL spurious_valid: got valid=%b%b%b at cycle %0d, exp valid=000",
                  rd_valid_a, rd_valid_b, rd_valid_c, cyc);
      end
   end

   task automatic push(input kind_e k, input string name, input int ea, input int eb,
                       input int ec, input int ga, input int gb, input int gc);
      sb_t e;
      e.kind = k;
      e.due  = cyc + 1;
      e.name = name;
      e.ea = ea; e.eb = eb; e.ec = ec;
      e.ga = ga; e.gb = gb; e.gc = gc;
      sb.push_back(e);
   endtask

   task automatic idle_inputs();
      clear_rq = 1'b0;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr  = '0;
   endtask

   // One cycle of access; a read (without clear) expects data a/b/c one edge later.
   task automatic op(input string name, input logic clr, input logic we, input logic [8:0] wa,
                     input logic [7:0] wd, input logic re, input logic [8:0] ra,
                     input int ea, input int eb, input int ec);
      clear_rq = clr;
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
      rd_en    = re;
      rd_addr  = ra;
      if (re && !clr) push(KRead, name, ea, eb, ec, 0, 0, 0);
      @(negedge clk);
      idle_inputs();
   endtask

   // Idle cycle; after its edge rd_valid must be 0 and rd_data must equal a/b/c.
   task automatic hold(input string name, input int ea, input int eb, input int ec);
      idle_inputs();
      push(KHold, name, ea, eb, ec, 0, 0, 0);
      @(negedge clk);
   endtask

   // Counts busy-high falling edges over n cycles, starting with the current one. Optionally
   // pulses clear_rq at cycle clr_at and issues a write+read of addr 3 at cycle acc_at.
   task automatic run_busy(input string name, input int n, input int clr_at, input int acc_at,
                           input int ea, input int eb, input int ec);
      int ca, cb, cc;
      ca = 0; cb = 0; cc = 0;
      for (int i = 0; i < n; i++) begin
         if (busy_a) ca++;
         if (busy_b) cb++;
         if (busy_c) cc++;
         clear_rq = (i == clr_at);
         wr_en    = (i == acc_at);
         rd_en    = (i == acc_at);
         wr_addr  = 9'd3;
         wr_data  = 8'h77;
         rd_addr  = 9'd3;
         @(negedge clk);
      end
      idle_inputs();
      push(KVal, name, ea, eb, ec, ca, cb, cc);
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();

      // 1. reset, power-up clear length, first read
      @(negedge clk);
      hold("reset_state", 0, 0, 0);
      reset = 1'b1;
      run_busy("busy_after_reset", 600, -1, -1, 512, 512, 300);
      op("read_after_reset", 0, 0, 0, 0, 1, 9'd5, 0, 0, 0);

      // 2. write then read, then hold with rd_en low
      op("write_a5", 0, 1, 9'd3, 8'hA5, 0, 0, 0, 0, 0);
      op("read_a5", 0, 0, 0, 0, 1, 9'd3, 8'hA5, 8'hA5, 8'hA5);
      hold("hold_a5", 8'hA5, 8'hA5, 8'hA5);

      // 3. same-address write/read
      op("write_11", 0, 1, 9'd7, 8'h11, 0, 0, 0, 0, 0);
      op("bypass_same_addr", 0, 1, 9'd7, 8'h3C, 1, 9'd7, 8'h3C, 8'h11, 8'h3C);
      op("reread_3c", 0, 0, 0, 0, 1, 9'd7, 8'h3C, 8'h3C, 8'h3C);
      op("no_bypass_diff_addr", 0, 1, 9'd8, 8'h22, 1, 9'd7, 8'h3C, 8'h3C, 8'h3C);

      // 4. fill, clear with a colliding access, ignored second clear request
      for (int i = 0; i < 10; i++) begin
         op("fill", 0, 1, 9'(i), 8'(8'h10 + i), 0, 0, 0, 0, 0);
      end
      op("read_fill_9", 0, 0, 0, 0, 1, 9'd9, 8'h19, 8'h19, 8'h19);
      op("clear_with_access", 1, 1, 9'd20, 8'h55, 1, 9'd0, 0, 0, 0);
      run_busy("busy_clear_rq", 600, 99, -1, 512, 512, 300);
      for (int i = 0; i < 10; i++) begin
         op("read_cleared", 0, 0, 0, 0, 1, 9'(i), 0, 0, 0);
      end

      // 5. out-of-range accesses (only c has DEPTH=300)
      op("write_299", 0, 1, 9'd299, 8'h42, 0, 0, 0, 0, 0);
      op("write_310", 0, 1, 9'd310, 8'hFF, 0, 0, 0, 0, 0);
      op("read_310", 0, 0, 0, 0, 1, 9'd310, 8'hFF, 8'hFF, 8'h00);
      op("read_299", 0, 0, 0, 0, 1, 9'd299, 8'h42, 8'h42, 8'h42);

      // 6. reset mid-clear at clr_ptr=200, access during busy ignored
      op("start_clear", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (200) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run_busy("busy_after_midclear_reset", 600, -1, 250, 512, 512, 300);
      op("read_3_after_busy_write", 0, 0, 0, 0, 1, 9'd3, 0, 0, 0);
      op("read_299_cleared", 0, 0, 0, 0, 1, 9'd299, 0, 0, 0);
      op("read_310_cleared", 0, 0, 0, 0, 1, 9'd310, 0, 0, 0);

      repeat (3) @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
